// File: rtl/rv32m_div_pkg.sv
// Shared encodings and constants for the RV32M divide sequencer.
package rv32m_div_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration; purely combinational.
// Latency: 0 cycles. No backpressure.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   prem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] dvsr,
  output logic [XLEN:0]   prem_n,
  output logic [XLEN-1:0] quo_n
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] trial;

  always_comb begin
    shifted = {prem, quo[XLEN-1]};
    trial   = shifted - {2'b00, dvsr};
    // A borrow out of the top bit means the divisor did not fit: restore.
    if (trial[XLEN+1]) begin
      prem_n = shifted[XLEN:0];
      quo_n  = {quo[XLEN-2:0], 1'b0};
    end else begin
      prem_n = trial[XLEN:0];
      quo_n  = {quo[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU sequencer; optional result cache under DIV_RESULT_REUSE_EN.
// Latency: 33 cycles from start to done; 1 cycle for divide-by-zero, overflow or a cache hit.
// Backpressure: stall held while launching/iterating; done pulses once, then back to IDLE.
module div_sequencer
  import rv32m_div_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            start,
  input  logic            kill,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  div_state_t      state, state_n;
  logic [CNT_W-1:0] count;
  logic [1:0]      op_q;
  logic            q_neg_q, r_neg_q;
  logic [XLEN:0]   prem, prem_n;
  logic [XLEN-1:0] quo, quo_n, dvsr;

  logic            is_signed, a_neg, b_neg, div0, ovf, special, launch, last, hit;
  logic [XLEN-1:0] a_mag, b_mag, spec_res, fin_q, fin_r, hit_res;

  div_step #(.XLEN(XLEN)) u_step (
    .prem   (prem),
    .quo    (quo),
    .dvsr   (dvsr),
    .prem_n (prem_n),
    .quo_n  (quo_n)
  );

  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & dividend[XLEN-1];
    b_neg     = is_signed & divisor[XLEN-1];
    a_mag     = a_neg ? -dividend : dividend;
    b_mag     = b_neg ? -divisor : divisor;
    div0      = (divisor == '0);
    ovf       = is_signed & (dividend == INT_MIN) & (divisor == DIV0_QUOT);
    special   = div0 | ovf;
    if (div0) spec_res = op[1] ? dividend : DIV0_QUOT;
    else      spec_res = op[1] ? '0 : INT_MIN;
    launch    = (state == IDLE) & start & ~kill;
    last      = (count == CNT_W'(XLEN - 1));
    fin_q     = q_neg_q ? -quo_n : quo_n;
    fin_r     = r_neg_q ? -prem_n[XLEN-1:0] : prem_n[XLEN-1:0];
    stall     = launch | (state == BUSY);
    done      = (state == DONE);
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (launch) state_n = (special | hit) ? DONE : BUSY;
      BUSY:    if (last) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (kill) state_n = IDLE;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      count   <= '0;
      op_q    <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      prem    <= '0;
      quo     <= '0;
      dvsr    <= '0;
      result  <= '0;
    end else begin
      state <= state_n;
      if (launch) begin
        op_q    <= op;
        q_neg_q <= a_neg ^ b_neg;
        r_neg_q <= a_neg;
        prem    <= '0;
        quo     <= a_mag;
        dvsr    <= b_mag;
        count   <= '0;
        if (special)  result <= spec_res;
        else if (hit) result <= hit_res;
      end else if ((state == BUSY) && !kill) begin
        prem  <= prem_n;
        quo   <= quo_n;
        count <= count + CNT_W'(1);
        if (last) result <= op_q[1] ? fin_r : fin_q;
      end
    end
  end

`ifdef DIV_RESULT_REUSE_EN
  logic            c_vld, c_sgn;
  logic [XLEN-1:0] c_a, c_b, c_q, c_r;

  assign hit     = c_vld & (c_a == dividend) & (c_b == divisor) & (c_sgn == is_signed);
  assign hit_res = op[1] ? c_r : c_q;

  // Operands are captured at launch with the entry marked invalid; it only
  // becomes valid if that same op runs to completion, so a kill leaves it dead.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      c_vld <= 1'b0;
      c_sgn <= 1'b0;
      c_a   <= '0;
      c_b   <= '0;
      c_q   <= '0;
      c_r   <= '0;
    end else if (launch && special) begin
      c_vld <= 1'b0;
    end else if (launch && !hit) begin
      c_vld <= 1'b0;
      c_a   <= dividend;
      c_b   <= divisor;
      c_sgn <= is_signed;
    end else if ((state == BUSY) && !kill && last) begin
      c_vld <= 1'b1;
      c_q   <= fin_q;
      c_r   <= fin_r;
    end
  end
`else
  assign hit     = 1'b0;
  assign hit_res = '0;
`endif

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: latency, signed/unsigned results, special cases, kill, reset.
module tb_div_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        start = 1'b0;
  logic        kill = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        stall, done;
  logic [31:0] result;

  int nerr = 0;
  int nchk = 0;

`ifdef DIV_RESULT_REUSE_EN
  localparam int PAIR_LAT = 1;
`else
  localparam int PAIR_LAT = 33;
`endif

  div_sequencer #(.XLEN(32), .CNT_W(5)) dut (
    .CLK(CLK), .RESET(RESET), .start(start), .kill(kill), .op(op),
    .dividend(dividend), .divisor(divisor),
    .stall(stall), .done(done), .result(result)
  );

  always #5 CLK = ~CLK;

  // Issues one op and follows it to done; lat=-1 if done never arrives.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output int lat, output int stall_bad);
    @(negedge CLK);
    op = o; dividend = a; divisor = b; start = 1'b1;
    lat = -1; stall_bad = 0; r = 'x;
    for (int c = 0; c < 100; c++) begin
      #1;
      if (done) begin
        lat = c; r = result;
        if (stall) stall_bad++;
        break;
      end
      if (!stall) stall_bad++;
      @(negedge CLK);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    nchk++; if (done !== 1'b0)   begin nerr++; $display("FAIL reset_done: got %b want 0", done); end
    nchk++; if (stall !== 1'b0)  begin nerr++; $display("FAIL reset_stall: got %b want 0", stall); end
    nchk++; if (result !== 32'h0) begin nerr++; $display("FAIL reset_result: got %h want 0", result); end
    @(negedge CLK); RESET = 1'b0;
  endtask

  // op, dividend, divisor, expected result, expected latency
  task automatic run_table(input string tag, input logic [1:0] o[], input logic [31:0] a[],
                           input logic [31:0] b[], input logic [31:0] e[], input int el[]);
    logic [31:0] r; int lat, sb;
    for (int i = 0; i < o.size(); i++) begin
      do_op(o[i], a[i], b[i], r, lat, sb);
      nchk++; if (r !== e[i]) begin nerr++; $display("FAIL %s[%0d]_result: got %h want %h", tag, i, r, e[i]); end
      nchk++; if (lat !== el[i]) begin nerr++; $display("FAIL %s[%0d]_latency: got %0d want %0d", tag, i, lat, el[i]); end
      nchk++; if (sb !== 0) begin nerr++; $display("FAIL %s[%0d]_stall: got %0d bad cycles want 0", tag, i, sb); end
    end
  endtask

  task automatic test_basic;
    run_table("basic", '{2'b00, 2'b10}, '{32'd100, 32'd100}, '{32'd7, 32'd7},
              '{32'd14, 32'd2}, '{33, PAIR_LAT});
  endtask

  task automatic test_signed;
    run_table("signed", '{2'b00, 2'b10, 2'b01, 2'b11},
              '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
              '{32'd2, 32'd2, 32'd2, 32'd2},
              '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h1},
              '{33, PAIR_LAT, 33, PAIR_LAT});
  endtask

  task automatic test_div0;
    run_table("div0", '{2'b00, 2'b10, 2'b01}, '{32'd5, 32'd5, 32'd0}, '{32'd0, 32'd0, 32'd0},
              '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF}, '{1, 1, 1});
  endtask

  task automatic test_overflow;
    run_table("ovf", '{2'b00, 2'b10}, '{32'h8000_0000, 32'h8000_0000},
              '{32'hFFFF_FFFF, 32'hFFFF_FFFF}, '{32'h8000_0000, 32'h0}, '{1, 1});
  endtask

  task automatic test_kill;
    int pulses = 0;
    @(negedge CLK);
    op = 2'b00; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    repeat (10) @(negedge CLK);
    #1;
    nchk++; if (stall !== 1'b1) begin nerr++; $display("FAIL kill_busy_stall: got %b want 1", stall); end
    kill = 1'b1;
    @(negedge CLK);
    kill = 1'b0; start = 1'b0;
    #1;
    nchk++; if (stall !== 1'b0) begin nerr++; $display("FAIL kill_stall: got %b want 0", stall); end
    for (int c = 0; c < 40; c++) begin
      if (done) pulses++;
      @(negedge CLK); #1;
    end
    nchk++; if (pulses !== 0) begin nerr++; $display("FAIL kill_no_done: got %0d pulses want 0", pulses); end
    run_table("after_kill", '{2'b00}, '{32'd9}, '{32'd3}, '{32'd3}, '{33});
  endtask

  task automatic test_reset_mid;
    @(negedge CLK);
    op = 2'b00; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    repeat (20) @(negedge CLK);
    #1;
    RESET = 1'b1; start = 1'b0;
    #1;
    nchk++; if (done !== 1'b0)    begin nerr++; $display("FAIL rst_mid_done: got %b want 0", done); end
    nchk++; if (stall !== 1'b0)   begin nerr++; $display("FAIL rst_mid_stall: got %b want 0", stall); end
    nchk++; if (result !== 32'h0) begin nerr++; $display("FAIL rst_mid_result: got %h want 0", result); end
    @(negedge CLK); RESET = 1'b0;
  endtask

  task automatic test_reuse;
    run_table("reuse", '{2'b00, 2'b10, 2'b01}, '{32'd100, 32'd100, 32'd100},
              '{32'd7, 32'd7, 32'd7}, '{32'd14, 32'd2, 32'd14}, '{33, PAIR_LAT, 33});
  endtask

  initial begin
    test_reset;
    test_basic;
    test_signed;
    test_div0;
    test_overflow;
    test_kill;
    test_reset_mid;
    test_reuse;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle controller and iterative datapath for the RV32M divide group: DIV, DIVU, REM, REMU.
- Sits beside the EX-stage ALU. When the control unit decodes a divide, EX raises `start`.
- The block stalls the pipeline while it iterates, then returns one result for exactly one cycle.
- Single-cycle ALU opcodes are unaffected.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W = XLEN.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  asynchronous, active-high reset.
- start  input  1  EX holds a divide op; held high until `done` is seen.
- kill  input  1  pipeline flush; aborts any operation in flight.
- op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU.
- dividend  input  XLEN  rs1 value.
- divisor  input  XLEN  rs2 value.
- stall  output  1  freezes PC, IF/ID and ID/EX.
- done  output  1  result valid this cycle.
- result  output  XLEN  quotient or remainder.

Behaviour:
- Clock and reset: one clock (CLK); RESET is asynchronous, active-high. On reset: state=IDLE, count=0, all internal registers 0, done=0, result=0, stall=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - start=1 and kill=0 at edge E0: latch op, sign flags, and magnitudes of the operands. DIVU/REMU operands are treated as unsigned.
  - Divisor==0 → go to DONE. Quotient = all ones; remainder = dividend.
  - Signed op with dividend=0x80000000 and divisor=0xFFFFFFFF → go to DONE. Quotient = 0x80000000; remainder = 0.
  - Otherwise → go to BUSY with count=0.
- BUSY:
  - One restoring shift-subtract step per edge; count increments each step.
  - The step with count=XLEN-1 (edge E32) moves to DONE.
  - start is ignored while in BUSY.
- DONE:
  - done=1 for exactly one cycle, then unconditionally back to IDLE.
  - Sign fix: quotient negated if the operand signs differ; remainder takes the dividend's sign (signed ops only).
  - start seen in DONE is the same instruction still in EX, so it is ignored.
- Latency:
  - Normal op: done high in the cycle after E32, i.e. 33 cycles including the start cycle.
  - Special cases: done high in the cycle after E0.
- stall = (IDLE & start & ~kill) | BUSY. stall is combinational and 0 in DONE, so EX captures `result` and advances.
- result:
  - Registered on entry to DONE.
  - Holds its value until the next DONE; never X after reset.
- kill:
  - In any state, returns to IDLE at the next edge; done is not asserted.
  - kill and start in the same IDLE cycle: start is ignored.
- RESET mid-operation: immediate return to IDLE; outputs go to their reset values.
- Arithmetic: partial remainder is XLEN+1 bits; the final remainder is XLEN bits.

Optional Feature:
- Macro: DIV_RESULT_REUSE_EN.
- With the macro defined:
  - The block keeps the last completed operands, signedness, quotient and remainder.
  - A start with identical dividend, divisor and signedness (e.g. DIV then REM) goes IDLE→DONE in one cycle, returning the cached quotient or remainder as selected by op[1].
  - The cache is invalidated by RESET, by kill during BUSY, and by any special-case operation.
- Without the macro: every op that is not a special case takes the full 33 cycles; no cache registers are built.

Decomposition:
- Package rv32m_div_pkg holds:
  - op encoding constants: OP_DIV, OP_DIVU, OP_REM, OP_REMU;
  - the state enum {IDLE, BUSY, DONE};
  - constants DIV0_QUOT (all ones) and INT_MIN (0x80000000).
- One sub-module, div_step: combinational single restoring iteration.
  - Inputs: partial remainder, quotient bit stream, divisor.
  - Outputs: next partial remainder, next quotient.
  - Instantiated once inside div_sequencer.

Test Plan:
- DIV 100/7:
  - start at E0 → stall=1 for cycles 0–32, done in cycle 33 with result=14.
  - Then REM 100/7 → result=2.
- Signed and unsigned cases:
  - DIV −7/2 → 0xFFFFFFFD (−3).
  - REM −7/2 → 0xFFFFFFFF (−1).
  - DIVU 0xFFFFFFFF/2 → 0x7FFFFFFF.
  - REMU 0xFFFFFFFF/2 → 1.
- Divide by zero:
  - DIV 5/0 → done the cycle after start, result 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIVU 0/0 → 0xFFFFFFFF.
- Overflow:
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000 after 1 cycle.
  - REM on the same operands → 0.
- kill asserted at cycle 10 of a 1000/3 DIV:
  - next cycle state IDLE, stall=0, no done pulse;
  - a following DIV 9/3 completes normally with 3.
  - Also assert RESET at cycle 20 of another op: done, stall and result go to 0 immediately.
- With DIV_RESULT_REUSE_EN:
  - DIV 100/7 (33 cycles), then REM 100/7 → done 1 cycle after start, result 2.
  - DIVU 100/7 afterwards → full 33-cycle latency, result 14.
